// File: rtl/esc_pkg.sv
// esc_pkg: shared state and speed types for the ESC update scheduler
package esc_pkg;
  typedef enum logic [1:0] {ARMING, RUN, FAILSAFE, KILLED} esc_state_t;
  localparam int SPD_W = 11;
  typedef logic [SPD_W-1:0] spd_t;
endpackage

// File: rtl/esc_update_scheduler_if.sv
// esc_update_scheduler_if: flight-controller requests in, ESC speeds and write pulses out
interface esc_update_scheduler_if;
  import esc_pkg::*;
  spd_t frnt_spd_in, bck_spd_in, lft_spd_in, rght_spd_in;
  logic spd_vld, kill;
  spd_t frnt_spd, bck_spd, lft_spd, rght_spd;
  logic wrt_frnt, wrt_bck, wrt_lft, wrt_rght, armed, failsafe;
  modport master (
    output frnt_spd_in, bck_spd_in, lft_spd_in, rght_spd_in, spd_vld, kill,
    input  frnt_spd, bck_spd, lft_spd, rght_spd, wrt_frnt, wrt_bck, wrt_lft, wrt_rght, armed, failsafe
  );
  modport slave (
    input  frnt_spd_in, bck_spd_in, lft_spd_in, rght_spd_in, spd_vld, kill,
    output frnt_spd, bck_spd, lft_spd, rght_spd, wrt_frnt, wrt_bck, wrt_lft, wrt_rght, armed, failsafe
  );
endinterface

// File: rtl/esc_frame_timer.sv
// esc_frame_timer: PWM frame counter with frame_start and per-channel stagger strobes
module esc_frame_timer #(
  parameter int PERIOD  = 1048576,
  parameter int STAGGER = 8192
) (
  input  logic       clk,
  input  logic       rst,
  output logic       frame_start,
  output logic [3:0] stb
);
  localparam int CW = $clog2(PERIOD);
  logic [CW-1:0] frame_cnt;
  always_ff @(posedge clk)
    frame_cnt <= (rst || frame_cnt == CW'(PERIOD - 1)) ? '0 : frame_cnt + 1'b1;
  assign frame_start = frame_cnt == '0;
  // strobes fire one cycle early so the registered wrt lands on 1 + i*STAGGER
  for (genvar i = 0; i < 4; i++) begin : g_stb
    assign stb[i] = frame_cnt == CW'(i * STAGGER);
  end
endmodule

// File: rtl/esc_update_scheduler.sv
// esc_update_scheduler: shadows FC speeds, commits once per frame, staggers ESC writes, arm/failsafe/kill FSM
module esc_update_scheduler
  import esc_pkg::*;
#(
  parameter int PERIOD         = 1048576,
  parameter int STAGGER        = 8192,
  parameter int ARM_FRAMES     = 64,
  parameter int TIMEOUT_FRAMES = 8
) (
  input logic clk,
  input logic rst,
  esc_update_scheduler_if.slave bus
);
  localparam int AW = $clog2(ARM_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [AW-1:0] ARM_MAX = AW'(ARM_FRAMES);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_FRAMES);
  esc_state_t state, nxt;
  logic [AW-1:0] arm_cnt;
  logic [TW-1:0] timeout_cnt;
  logic fresh, heard, frame_start, armed, failsafe;
  logic [3:0] stb, wrt;
  spd_t [3:0] shadow, spd, spd_in, commit;
  esc_frame_timer #(.PERIOD(PERIOD), .STAGGER(STAGGER)) u_timer (
    .clk(clk), .rst(rst), .frame_start(frame_start), .stb(stb)
  );
  assign spd_in = {bus.rght_spd_in, bus.lft_spd_in, bus.bck_spd_in, bus.frnt_spd_in};
  assign heard  = fresh || bus.spd_vld;
  always_comb
    nxt = bus.kill ? KILLED :
          state == ARMING   ? ((frame_start && arm_cnt == ARM_MAX) ? RUN : ARMING) :
          state == RUN      ? ((frame_start && !heard && timeout_cnt >= TO_MAX - 1'b1) ? FAILSAFE : RUN) :
          state == FAILSAFE ? (bus.spd_vld ? ARMING : FAILSAFE) : KILLED;
  // only a frame that both starts and stays in RUN carries real throttle
  assign commit = (state == RUN && nxt == RUN) ? (bus.spd_vld ? spd_in : shadow) : '0;
  always_ff @(posedge clk)
    if (rst) begin
      state       <= ARMING;
      arm_cnt     <= '0;
      timeout_cnt <= '0;
      fresh       <= 1'b0;
      shadow      <= '0;
      spd         <= '0;
      wrt         <= '0;
      armed       <= 1'b0;
      failsafe    <= 1'b0;
    end else begin
      state       <= nxt;
      arm_cnt     <= (state != ARMING) ? '0 : arm_cnt + AW'(frame_start);
      timeout_cnt <= (state == ARMING) ? '0 : !frame_start ? timeout_cnt :
                     heard ? '0 : timeout_cnt + TW'(timeout_cnt != TO_MAX);
      fresh       <= !frame_start && heard;
      if (bus.spd_vld) shadow <= spd_in;
      if (frame_start) spd <= commit;
      wrt         <= stb;
      armed       <= nxt == RUN;
      failsafe    <= nxt == FAILSAFE || nxt == KILLED;
    end
  assign bus.frnt_spd = spd[0];
  assign bus.bck_spd  = spd[1];
  assign bus.lft_spd  = spd[2];
  assign bus.rght_spd = spd[3];
  assign bus.wrt_frnt = wrt[0];
  assign bus.wrt_bck  = wrt[1];
  assign bus.wrt_lft  = wrt[2];
  assign bus.wrt_rght = wrt[3];
  assign bus.armed    = armed;
  assign bus.failsafe = failsafe;
endmodule

// File: doc/esc_update_scheduler.md
Name: esc_update_scheduler

Overview:
- Sequences the four ESC PWM channels (front, back, left, right) of the quadcopter.
- Holds a shadow copy of the four motor speeds from the flight controller.
- Commits the shadow to the ESC SPEED inputs once per PWM frame, then issues one staggered wrt pulse per channel.
- Runs an arm / failsafe / kill state machine that forces zero throttle when required.
- Sits between the flight controller and four ESC interface instances.

Parameters:
- PERIOD, 1048576, frame length in clk cycles (about 21 ms at 50 MHz); legal range 4*STAGGER+2 .. 2^21.
- STAGGER, 8192, clk cycles between successive channel wrt pulses within a frame.
- ARM_FRAMES, 64, frames of forced zero speed after reset or re-arm.
- TIMEOUT_FRAMES, 8, consecutive frame starts without a new speed set before entering FAILSAFE.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous active-high reset
- frnt_spd_in  in  11  requested front motor speed
- bck_spd_in  in  11  requested back motor speed
- lft_spd_in  in  11  requested left motor speed
- rght_spd_in  in  11  requested right motor speed
- spd_vld  in  1  one-cycle strobe; all four *_spd_in are valid
- kill  in  1  level; forces KILLED (sticky until rst)
- frnt_spd  out  11  SPEED to front ESC
- bck_spd  out  11  SPEED to back ESC
- lft_spd  out  11  SPEED to left ESC
- rght_spd  out  11  SPEED to right ESC
- wrt_frnt, wrt_bck, wrt_lft, wrt_rght  out  1 each  one-cycle ESC write pulses
- armed  out  1  high only in RUN
- failsafe  out  1  high in FAILSAFE or KILLED

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; all state updates on posedge clk.
- Reset values: all *_spd = 0, all wrt_* = 0, armed = 0, failsafe = 0, frame_cnt = 0, shadow regs = 0, state = ARMING, arm_cnt = 0, timeout_cnt = 0, fresh = 0.
- frame_cnt counts 0..PERIOD-1 and wraps to 0. frame_start is frame_cnt == 0.
- Shadow: spd_vld loads all four shadow registers and sets fresh.
- Commit: on frame_start, *_spd outputs are registered, so the new value is visible the cycle after frame_start. Outputs hold constant for the rest of the frame.
  - In RUN, commit the shadow. If spd_vld is high in the frame_start cycle, commit the incoming *_spd_in (bypass).
  - In every other state, commit 0.
- wrt pulses: wrt_frnt at frame_cnt == 1, wrt_bck at 1+STAGGER, wrt_lft at 1+2*STAGGER, wrt_rght at 1+3*STAGGER. Each is registered and lasts exactly one cycle.
- Pulses are issued in every state, so the ESCs keep receiving zero-throttle refreshes.
- Timeout counting, evaluated on each frame_start:
  - If fresh (or spd_vld this cycle), clear timeout_cnt and clear fresh.
  - Otherwise timeout_cnt increments, saturating at TIMEOUT_FRAMES.
- State transitions:
  - ARMING: arm_cnt increments on each frame_start. When arm_cnt reaches ARM_FRAMES, go to RUN at that frame_start; that frame's commit is still 0. timeout_cnt is held at 0 while ARMING.
  - RUN: go to FAILSAFE on the frame_start where timeout_cnt would reach TIMEOUT_FRAMES; that frame commits 0.
  - FAILSAFE: any spd_vld goes to ARMING with arm_cnt = 0.
  - Any state: kill high goes to KILLED on the next edge. kill has priority over all other transitions.
  - KILLED: exit only via rst.
- Kill asserted mid-frame: the next commit is 0. Outputs already committed are held until that next frame_start. Channels whose wrt pulse is still pending in the current frame still pulse with the held value.
- rst asserted mid-frame: all outputs return to reset values on the next edge, and any pending wrt pulses are cancelled.
- Arithmetic: counters sized with $clog2 of their parameter. No speed arithmetic or saturation is done here; the ESC applies its own scaling.

Decomposition:
- Shared package esc_pkg:
  - typedef enum logic [1:0] {ARMING, RUN, FAILSAFE, KILLED} esc_state_t
  - localparam SPD_W = 11
  - typedef logic [SPD_W-1:0] spd_t
- Natural sub-module: esc_frame_timer. It holds frame_cnt and produces frame_start plus the four stagger strobes from PERIOD and STAGGER.
- The FSM, shadow registers and commit logic stay in the top module.

Test Plan:
Bench parameters: PERIOD=100, STAGGER=4, ARM_FRAMES=3, TIMEOUT_FRAMES=2.
- Reset and arming: rst, then spd_vld every frame with 11'h400 on all channels.
  - All *_spd = 0 for frames 0..3; armed rises at frame 3 start; 11'h400 appears after frame 4 start.
  - wrt pulses at frame_cnt 1, 5, 9, 13 of every frame.
- Bypass: in RUN, shadow = 11'h100, then spd_vld with 11'h7FF exactly at frame_cnt == 0 -> that frame's commit is 11'h7FF.
- Timeout: in RUN, stop spd_vld -> failsafe = 1 and zero commit on the second frame_start without a strobe. A following spd_vld -> ARMING, then 3 zero frames, then RUN.
- Kill mid-frame: assert kill at frame_cnt 7 with outputs at 11'h300.
  - wrt_lft at 9 and wrt_rght at 13 still see 11'h300.
  - Next frame commits 0; failsafe = 1; state stays KILLED despite spd_vld until rst.
- Reset mid-frame: assert rst at frame_cnt 3 -> no wrt_bck at 5; all outputs 0; arming restarts with frame_cnt = 0.
